// File: rtl/ladybird_lsu.sv
// ladybird_lsu: single-outstanding load/store unit between the memory stage and the data MMU.
// Optional misaligned-access trap: define LADYBIRD_LSU_MISALIGN_TRAP_EN.
module ladybird_lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                anrst,
    input  logic                nrst,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [XLEN-1:0]     i_addr,
    input  logic [XLEN-1:0]     i_data,
    input  logic [2:0]          i_funct3,
    input  logic                i_store,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [XLEN-1:0]     o_data,
    output logic                o_error,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [XLEN-1:0]     m_addr,
    output logic [XLEN-1:0]     m_data,
    output logic [XLEN/8-1:0]   m_wstrb,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [XLEN-1:0]     s_data
);

    typedef enum logic [1:0] {
        IDLE,
        BUS_REQ,
        BUS_RESP,
        DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_off;
    logic [2:0]          r_funct3;
    logic                r_store;
    logic                r_i_ready;
    logic                r_o_valid;
    logic [XLEN-1:0]     r_o_data;
    logic                r_o_error;
    logic                r_m_valid;
    logic [XLEN-1:0]     r_m_addr;
    logic [XLEN-1:0]     r_m_data;
    logic [XLEN/8-1:0]   r_m_wstrb;
    logic                r_s_ready;

    logic                w_illegal;
    logic                w_misalign;
    logic [XLEN/8-1:0]   w_strb;
    logic [XLEN-1:0]     w_lane_data;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [XLEN-1:0]     w_load_data;

    assign w_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_store && i_funct3[2]);

`ifdef LADYBIRD_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_strb      = '0;
        w_lane_data = i_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << i_addr[1:0];
                w_lane_data = {4{i_data[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << {i_addr[1], 1'b0};
                w_lane_data = {2{i_data[15:0]}};
            end
            default: begin
                w_strb      = '1;
                w_lane_data = i_data;
            end
        endcase
        if (!i_store) begin
            w_strb = '0;
        end
    end

    assign w_byte = s_data[{r_off, 3'b000} +: 8];
    assign w_half = s_data[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = s_data;
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = s_data;
        endcase
    end

    // The synchronous clear duplicates the asynchronous reset values exactly.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_funct3  <= '0;
            r_store   <= 1'b0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_error <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_data  <= '0;
            r_m_wstrb <= '0;
            r_s_ready <= 1'b0;
        end else if (!nrst) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_funct3  <= '0;
            r_store   <= 1'b0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_error <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_data  <= '0;
            r_m_wstrb <= '0;
            r_s_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_off     <= i_addr[1:0];
                        r_funct3  <= i_funct3;
                        r_store   <= i_store;
                        r_i_ready <= 1'b0;
                        if (w_illegal || w_misalign) begin
                            r_o_valid <= 1'b1;
                            r_o_data  <= '0;
                            r_o_error <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_m_valid <= 1'b1;
                            r_m_addr  <= {i_addr[XLEN-1:2], 2'b00};
                            r_m_data  <= w_lane_data;
                            r_m_wstrb <= w_strb;
                            r_state   <= BUS_REQ;
                        end
                    end
                end
                BUS_REQ: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= BUS_RESP;
                    end
                end
                BUS_RESP: begin
                    if (s_valid) begin
                        r_s_ready <= 1'b0;
                        r_o_valid <= 1'b1;
                        r_o_error <= 1'b0;
                        r_o_data  <= r_store ? '0 : w_load_data;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_ready = r_i_ready;
    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;
    assign o_error = r_o_error;
    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_data  = r_m_data;
    assign m_wstrb = r_m_wstrb;
    assign s_ready = r_s_ready;

endmodule

// File: tb/tb_ladybird_lsu.sv
// Directed self-checking bench for ladybird_lsu; follows LADYBIRD_LSU_MISALIGN_TRAP_EN if defined.
module tb_ladybird_lsu;

    logic        clk;
    logic        anrst;
    logic        nrst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [2:0]  i_funct3;
    logic        i_store;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_error;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_wstrb;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    ladybird_lsu #(.XLEN(32)) dut (
        .clk      (clk),
        .anrst    (anrst),
        .nrst     (nrst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_funct3 (i_funct3),
        .i_store  (i_store),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_error  (o_error),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_wstrb  (m_wstrb),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_i_ready"}, {31'd0, i_ready}, 32'd1);
        check({tag, "_o_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_o_data"},  o_data, 32'd0);
        check({tag, "_o_error"}, {31'd0, o_error}, 32'd0);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_m_addr"},  m_addr, 32'd0);
        check({tag, "_m_data"},  m_data, 32'd0);
        check({tag, "_m_wstrb"}, {28'd0, m_wstrb}, 32'd0);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    endtask

    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic st);
        check({tag, "_acc_rdy"}, {31'd0, i_ready}, 32'd1);
        i_valid  = 1'b1;
        i_addr   = a;
        i_data   = d;
        i_funct3 = f3;
        i_store  = st;
        tick();
        i_valid  = 1'b0;
        i_addr   = 32'hFFFF_FFFF;
        i_data   = 32'h5555_5555;
        check({tag, "_busy_rdy"}, {31'd0, i_ready}, 32'd0);
    endtask

    task automatic bus_beat(input string tag, input logic [31:0] ea, input logic [3:0] es,
                            input logic [31:0] ed, input logic chk_data, input logic [31:0] rd);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_m_addr"},  m_addr, ea);
        check({tag, "_m_wstrb"}, {28'd0, m_wstrb}, {28'd0, es});
        if (chk_data) check({tag, "_m_data"}, m_data, ed);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
        check({tag, "_m_drop"},  {31'd0, m_valid}, 32'd0);
        s_valid = 1'b1;
        s_data  = rd;
        tick();
        s_valid = 1'b0;
        s_data  = 32'h0BAD_0BAD;
        check({tag, "_s_rdy_lo"}, {31'd0, s_ready}, 32'd0);
    endtask

    task automatic finish_xact(input string tag, input logic [31:0] ed, input logic ee);
        check({tag, "_o_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_o_data"},  o_data, ed);
        check({tag, "_o_error"}, {31'd0, o_error}, {31'd0, ee});
        check({tag, "_i_rdy_done"}, {31'd0, i_ready}, 32'd0);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        check({tag, "_o_drop"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_i_rdy_back"}, {31'd0, i_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        anrst = 1'b0; nrst = 1'b1;
        i_valid = 1'b0; i_addr = '0; i_data = '0; i_funct3 = '0; i_store = 1'b0;
        o_ready = 1'b0; m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        anrst = 1'b1;
        tick();

        // SB 0x1003: lane 3 strobe, byte replicated
        issue("sb", 32'h0000_1003, 32'hAABB_CCDD, 3'b000, 1'b1);
        bus_beat("sb", 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b1, 32'h1357_9BDF);
        finish_xact("sb", 32'h0, 1'b0);

        issue("sh", 32'h0000_1002, 32'h1234_BEEF, 3'b001, 1'b1);
        bus_beat("sh", 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0);
        finish_xact("sh", 32'h0, 1'b0);

        issue("sw", 32'h0000_1004, 32'hCAFE_F00D, 3'b010, 1'b1);
        bus_beat("sw", 32'h0000_1004, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0);
        finish_xact("sw", 32'h0, 1'b0);

        issue("lb", 32'h0000_2001, 32'h0, 3'b000, 1'b0);
        bus_beat("lb", 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 32'h1234_F678);
        finish_xact("lb", 32'hFFFF_FFF6, 1'b0);

        issue("lbu", 32'h0000_2001, 32'h0, 3'b100, 1'b0);
        bus_beat("lbu", 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 32'h1234_F678);
        finish_xact("lbu", 32'h0000_00F6, 1'b0);

        issue("lhu", 32'h0000_2002, 32'h0, 3'b101, 1'b0);
        bus_beat("lhu", 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 32'h1234_F678);
        finish_xact("lhu", 32'h0000_1234, 1'b0);

        issue("lh", 32'h0000_2002, 32'h0, 3'b001, 1'b0);
        bus_beat("lh", 32'h0000_2000, 4'b0000, 32'h0, 1'b0, 32'h8001_0000);
        finish_xact("lh", 32'hFFFF_8001, 1'b0);

        // LW with bus and result back-pressure; stray s_valid during BUS_REQ must be ignored
        issue("lws", 32'h0000_3000, 32'h0, 3'b010, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_DEAD;
        for (int i = 0; i < 5; i++) begin
            check("lws_m_valid_hold", {31'd0, m_valid}, 32'd1);
            check("lws_m_addr_hold",  m_addr, 32'h0000_3000);
            check("lws_m_wstrb_hold", {28'd0, m_wstrb}, 32'd0);
            check("lws_i_ready_hold", {31'd0, i_ready}, 32'd0);
            check("lws_s_ready_lo",   {31'd0, s_ready}, 32'd0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lws_s_wait", {31'd0, s_ready}, 32'd1);
            check("lws_o_wait", {31'd0, o_valid}, 32'd0);
            tick();
        end
        s_valid = 1'b1;
        s_data  = 32'hCAFE_BABE;
        tick();
        s_valid = 1'b0;
        s_data  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("lws_o_valid_hold", {31'd0, o_valid}, 32'd1);
            check("lws_o_data_hold",  o_data, 32'hCAFE_BABE);
            check("lws_i_ready_done", {31'd0, i_ready}, 32'd0);
            tick();
        end
        finish_xact("lws", 32'hCAFE_BABE, 1'b0);

        // Misaligned word
        issue("lwm", 32'h0000_3002, 32'h0, 3'b010, 1'b0);
`ifdef LADYBIRD_LSU_MISALIGN_TRAP_EN
        check("lwm_no_bus", {31'd0, m_valid}, 32'd0);
        finish_xact("lwm", 32'h0, 1'b1);
        check("lwm_no_bus_after", {31'd0, m_valid}, 32'd0);
`else
        bus_beat("lwm", 32'h0000_3000, 4'b0000, 32'h0, 1'b0, 32'h1122_3344);
        finish_xact("lwm", 32'h1122_3344, 1'b0);
`endif

        issue("f011", 32'h0000_4000, 32'h0, 3'b011, 1'b0);
        check("f011_no_bus", {31'd0, m_valid}, 32'd0);
        finish_xact("f011", 32'h0, 1'b1);

        issue("sbu", 32'h0000_4000, 32'h0, 3'b100, 1'b1);
        check("sbu_no_bus", {31'd0, m_valid}, 32'd0);
        finish_xact("sbu", 32'h0, 1'b1);

        // Sync clear during BUS_REQ
        issue("nrst", 32'h0000_5008, 32'h0, 3'b010, 1'b0);
        check("nrst_m_valid", {31'd0, m_valid}, 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check_idle_outputs("nrst_clr");

        // Async reset during BUS_RESP
        issue("arst", 32'h0000_6000, 32'h0, 3'b010, 1'b0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("arst_in_resp", {31'd0, s_ready}, 32'd1);
        #2 anrst = 1'b0;
        #1;
        check_idle_outputs("arst");
        @(posedge clk);
        #1 anrst = 1'b1;
        tick();

        issue("post", 32'h0000_7003, 32'h0, 3'b100, 1'b0);
        bus_beat("post", 32'h0000_7000, 4'b0000, 32'h0, 1'b0, 32'h8899_AABB);
        finish_xact("post", 32'h0000_0088, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ladybird_lsu.md
# ladybird_lsu

Load/store unit between the core's memory stage and the data-side MMU. Accepts one load or store request per transaction, converts byte/halfword/word accesses into word-aligned bus beats with byte strobes, waits for the downstream response, and returns sign/zero-extended load data or a store acknowledge. Strictly one transaction outstanding; all handshakes are valid/ready.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- anrst  in  1  asynchronous active-low reset
- nrst  in  1  synchronous active-low clear, same effect as anrst, sampled on clk
- i_valid  in  1  request valid
- i_ready  out  1  request accepted when i_valid & i_ready
- i_addr  in  XLEN  byte address
- i_data  in  XLEN  store data, right-justified
- i_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_store  in  1  1 = store, 0 = load
- o_valid  out  1  result valid
- o_ready  in  1  result consumed when o_valid & o_ready
- o_data  out  XLEN  extended load data; 0 for stores and errors
- o_error  out  1  request rejected, no bus access made
- m_valid  out  1  bus request valid
- m_ready  in  1  bus request accepted
- m_addr  out  XLEN  word-aligned address {addr[31:2], 2'b00}
- m_data  out  XLEN  lane-replicated store data
- m_wstrb  out  XLEN/8  byte strobes; 0 for loads
- s_valid  in  1  bus response valid (loads and stores)
- s_ready  out  1  response accepted
- s_data  in  XLEN  bus read word

## Operation
- States: IDLE, BUS_REQ, BUS_RESP, DONE.
- IDLE: i_ready=1. On i_valid, latch addr, data, funct3, store. Illegal funct3 (011, 110, 111, or 100/101 with store) or misaligned (see Configuration) -> DONE with error flag set; otherwise -> BUS_REQ.
- BUS_REQ: m_valid=1; m_addr/m_data/m_wstrb driven from latched request, stable until m_ready. m_ready -> BUS_RESP.
- BUS_RESP: s_ready=1. s_valid -> capture result, -> DONE. s_valid outside BUS_RESP is ignored.
- DONE: o_valid=1, o_data/o_error held stable. o_ready -> IDLE.
- Store lanes, off = addr[1:0]: B: m_wstrb = 0001<<off, m_data = {4{data[7:0]}}; H: m_wstrb = 0011<<{addr[1],0}, m_data = {2{data[15:0]}}; W: 1111, data.
- Load extract: B/BU byte at s_data[8*off +: 8]; H/HU half at s_data[16*addr[1] +: 16]; W full word. B/H sign-extend, BU/HU zero-extend.
- Store result: o_data = 0, o_error = 0.

## Timing
- Reset (anrst low async, or nrst low at edge): state IDLE; latched regs 0; outputs o_valid=0, o_data=0, o_error=0, m_valid=0, m_addr=0, m_data=0, m_wstrb=0, s_ready=0; i_ready=1.
- Reset mid-transaction abandons it; an in-flight bus response is the bus owner's concern.
- Minimum latency: accept at edge T0; m_valid in cycle T1; m_ready at T1 -> s_ready at T2; s_valid at T2 -> o_valid at T3. Error path: o_valid in T1.
- i_ready=0 in all states but IDLE; no accept in the cycle o_valid&o_ready completes (next accept earliest the following cycle).
- Back-pressure: m_ready, s_valid, o_ready may stall indefinitely; all outputs held.

## Configuration
- LADYBIRD_LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, produces o_error=1, o_data=0, no bus beat.
- Undefined: misaligned requests never error; offending low bits are ignored (H uses addr[1], W uses word address), access proceeds normally.

## Test plan
- SB addr 0x1003 data 0xAABBCCDD -> m_addr 0x1000, m_wstrb 1000, m_data 0xDDDDDDDD; ack -> o_valid, o_data 0.
- LB addr 0x2001, s_data 0x1234F678 -> o_data 0xFFFFFFF6; LBU same -> 0x000000F6; LHU addr 0x2002 -> 0x00001234.
- LW addr 0x3000 with m_ready held low 5 cycles, o_ready low 3 cycles -> m_*/o_* stable throughout, i_ready 0, o_data = s_data.
- LW addr 0x3002: with macro -> o_error 1 in cycle after accept, m_valid never 1; without -> m_addr 0x3000, normal load.
- i_funct3 011 -> o_error 1, no bus beat, regardless of macro.
- Assert anrst while in BUS_RESP -> immediate IDLE, all outputs at reset values, next request completes normally.
